// File: rtl/spike_rate_decoder_if.sv
// Rate-result handshake bundle: producer drives the count and valid, consumer drives ready.
interface spike_rate_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] rate_out;
  logic             rate_valid;
  logic             rate_ready;

  modport master (output rate_out, output rate_valid, input rate_ready);
  modport slave  (input rate_out, input rate_valid, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Converts a 1-bit spike train into a windowed spike count (valid/ready) and a
// leaky, saturating synaptic current.
module spike_rate_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spike_in,
  input  logic                    en,
  input  logic [WIDTH-1:0]        win_len,
  input  logic [WIDTH-1:0]        weight,
  output logic [WIDTH-1:0]        syn_current,
  output logic                    missed,
  spike_rate_decoder_if.master    rate
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_cyc;
  logic [WIDTH-1:0] r_rate;
  logic             r_valid;
  logic             r_missed;
  logic [WIDTH-1:0] r_syn;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_cyc_nxt;
  logic [WIDTH-1:0] w_rate_nxt;
  logic             w_valid_nxt;
  logic             w_missed_nxt;
  logic [WIDTH-1:0] w_win_eff;
  logic [WIDTH-1:0] w_count_inc;
  logic             w_handshake;
  logic [SUM_W-1:0] w_syn_sum;
  logic [WIDTH-1:0] w_syn_nxt;

  // A zero-length window would never reach its final sample; run it as one cycle.
  assign w_win_eff   = (win_len == '0) ? WIDTH'(1) : win_len;
  assign w_count_inc = (spike_in && (r_count != MAX_VAL)) ? r_count + WIDTH'(1) : r_count;
  assign w_handshake = r_valid & rate.rate_ready;

  // Leaky integration: truncating decay plus weight, clamped at full scale.
  assign w_syn_sum = SUM_W'(r_syn >> SHIFT) + (spike_in ? SUM_W'(weight) : SUM_W'(0));
  assign w_syn_nxt = w_syn_sum[WIDTH] ? MAX_VAL : w_syn_sum[WIDTH-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_cyc_nxt    = r_cyc;
    w_rate_nxt   = r_rate;
    w_valid_nxt  = r_valid;
    w_missed_nxt = r_missed;

    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_cyc_nxt   = w_win_eff;
          w_count_nxt = '0;
          w_state_nxt = S_COUNT;
        end
      end

      S_COUNT: begin
        // Dropping en wins over the final-sample edge: the window is discarded.
        if (!en) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = w_count_inc;
          w_cyc_nxt   = r_cyc - WIDTH'(1);
          if (r_cyc == WIDTH'(1)) begin
            w_rate_nxt  = w_count_inc;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (spike_in) begin
          w_missed_nxt = 1'b1;
        end
        // Result stays put until consumed, regardless of en.
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          if (en) begin
            w_cyc_nxt   = w_win_eff;
            w_count_nxt = '0;
            w_state_nxt = S_COUNT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_cyc    <= '0;
      r_rate   <= '0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
      r_syn    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_cyc    <= w_cyc_nxt;
      r_rate   <= w_rate_nxt;
      r_valid  <= w_valid_nxt;
      r_missed <= w_missed_nxt;
      r_syn    <= w_syn_nxt;
    end
  end

  assign rate.rate_out   = r_rate;
  assign rate.rate_valid = r_valid;
  assign syn_current     = r_syn;
  assign missed          = r_missed;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: expected window counts are queued at stimulus
// time and popped whenever a result is handed over.
module tb_spike_rate_decoder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             spike_in;
  logic             en;
  logic [WIDTH-1:0] win_len;
  logic [WIDTH-1:0] weight;
  logic [WIDTH-1:0] syn_current;
  logic             missed;

  int n_total;
  int n_bad;
  int unsigned sb_q[$];

  spike_rate_decoder_if #(.WIDTH(WIDTH)) rate_if ();

  spike_rate_decoder #(.WIDTH(WIDTH), .SHIFT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .en          (en),
    .win_len     (win_len),
    .weight      (weight),
    .syn_current (syn_current),
    .missed      (missed),
    .rate        (rate_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!rate_if.rate_valid && n < budget) begin
      tick();
      n++;
    end
    if (!rate_if.rate_valid) check_eq("valid_timeout", 0, 1);
  endtask

  // Scoreboard: a handshake happens on the next edge whenever valid & ready here.
  always @(negedge clk) begin
    if (rst_n && rate_if.rate_valid && rate_if.rate_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(rate_if.rate_out), 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_rate", 32'(rate_if.rate_out), sb_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int unsigned exp_syn;
    int unsigned syn_seq[8];
    syn_seq = '{100, 50, 25, 12, 6, 3, 1, 0};
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b1;
    spike_in = 1'b0;
    en = 1'b0;
    win_len = '0;
    weight = '0;
    rate_if.rate_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_rate_out", 32'(rate_if.rate_out), 0);
    check_eq("rst_valid", 32'(rate_if.rate_valid), 0);
    check_eq("rst_syn", 32'(syn_current), 0);
    check_eq("rst_missed", 32'(missed), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Window of 8 with spikes at E1, E3, E5; consumer stalls for 5 cycles.
    win_len = 8'd8;
    en = 1'b1;
    sb_q.push_back(3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      spike_in = (k == 1 || k == 3 || k == 5);
      tick();
      if (k < 8) check_eq("w8_valid_early", 32'(rate_if.rate_valid), 0);
    end
    spike_in = 1'b0;
    check_eq("w8_valid", 32'(rate_if.rate_valid), 1);
    check_eq("w8_rate", 32'(rate_if.rate_out), 3);
    check_eq("w8_missed", 32'(missed), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("w8_hold_valid", 32'(rate_if.rate_valid), 1);
      check_eq("w8_hold_rate", 32'(rate_if.rate_out), 3);
    end
    en = 1'b0;
    rate_if.rate_ready = 1'b1;
    tick();
    rate_if.rate_ready = 1'b0;
    check_eq("w8_after_hs_valid", 32'(rate_if.rate_valid), 0);
    check_eq("w8_after_hs_rate", 32'(rate_if.rate_out), 3);

    // Zero-length window, constant spikes, always ready: a result every 2 cycles.
    win_len = 8'd0;
    spike_in = 1'b1;
    rate_if.rate_ready = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 5; k++) sb_q.push_back(1);
    tick();
    check_eq("w0_e0_valid", 32'(rate_if.rate_valid), 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq("w0_valid_pattern", 32'(rate_if.rate_valid), 32'(k % 2));
      if (k == 1) check_eq("w0_missed_e1", 32'(missed), 0);
      if (k == 2) check_eq("w0_missed_e2", 32'(missed), 1);
    end
    en = 1'b0;
    spike_in = 1'b0;
    tick();
    rate_if.rate_ready = 1'b0;
    check_eq("w0_end_valid", 32'(rate_if.rate_valid), 0);
    check_eq("w0_sb_drained", 32'(sb_q.size()), 0);

    // Full-length window with a spike every sample: count tops out at 255.
    win_len = 8'd255;
    spike_in = 1'b1;
    en = 1'b1;
    sb_q.push_back(255);
    tick();
    wait_valid(300, n);
    check_eq("w255_latency", 32'(n), 255);
    check_eq("w255_rate", 32'(rate_if.rate_out), 255);
    for (int k = 0; k < 45; k++) tick();
    check_eq("w255_hold_rate", 32'(rate_if.rate_out), 255);
    spike_in = 1'b0;
    en = 1'b0;
    rate_if.rate_ready = 1'b1;
    tick();
    rate_if.rate_ready = 1'b0;
    check_eq("w255_end_valid", 32'(rate_if.rate_valid), 0);

    // Abort at E6 of a 10-cycle window, then a fresh window starts from zero.
    win_len = 8'd10;
    en = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      spike_in = (k <= 4);
      if (k == 6) en = 1'b0;
      tick();
    end
    spike_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq("abort_valid", 32'(rate_if.rate_valid), 0);
    end
    en = 1'b1;
    rate_if.rate_ready = 1'b1;
    sb_q.push_back(2);
    tick();
    for (int k = 1; k <= 2; k++) begin
      spike_in = 1'b1;
      tick();
    end
    spike_in = 1'b0;
    wait_valid(20, n);
    check_eq("fresh_latency", 32'(n), 8);
    check_eq("fresh_rate", 32'(rate_if.rate_out), 2);
    en = 1'b0;
    tick();
    rate_if.rate_ready = 1'b0;

    // Synaptic current: decay of a single 100 kick, then saturation at 255.
    check_eq("syn_zero", 32'(syn_current), 0);
    weight = 8'd100;
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    check_eq("syn_decay", 32'(syn_current), syn_seq[0]);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq("syn_decay", 32'(syn_current), syn_seq[k]);
    end
    weight = 8'd200;
    spike_in = 1'b1;
    exp_syn = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_syn = (exp_syn >> 1) + 200;
      if (exp_syn > 255) exp_syn = 255;
      check_eq("syn_sat", 32'(syn_current), exp_syn);
    end
    check_eq("syn_sat_final", 32'(syn_current), 255);
    spike_in = 1'b0;
    weight = 8'd0;
    for (int k = 0; k < 10; k++) tick();
    check_eq("syn_settle", 32'(syn_current), 0);

    // Asynchronous reset in the middle of a window with count=5, current=60.
    win_len = 8'd20;
    en = 1'b1;
    tick();
    spike_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) weight = 8'd60;
      tick();
    end
    spike_in = 1'b0;
    weight = 8'd0;
    check_eq("pre_rst_syn", 32'(syn_current), 60);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rate_out", 32'(rate_if.rate_out), 0);
    check_eq("mid_rst_valid", 32'(rate_if.rate_valid), 0);
    check_eq("mid_rst_syn", 32'(syn_current), 0);
    check_eq("mid_rst_missed", 32'(missed), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    spike_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("post_rst_idle_missed", 32'(missed), 0);
      check_eq("post_rst_idle_valid", 32'(rate_if.rate_valid), 0);
    end
    win_len = 8'd2;
    en = 1'b1;
    rate_if.rate_ready = 1'b1;
    sb_q.push_back(2);
    tick();
    wait_valid(10, n);
    check_eq("post_rst_latency", 32'(n), 2);
    check_eq("post_rst_rate", 32'(rate_if.rate_out), 2);
    en = 1'b0;
    spike_in = 1'b0;
    tick();
    rate_if.rate_ready = 1'b0;
    tick();
    check_eq("sb_final_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
